l1_bus_arbiter: RTL and testbench
=================================

# l1_bus_arbiter

Shared-bus arbiter for the multicore L1 level. It sits between the per-core `cacheL1_control_unit` instances and the shared snoop bus. It collects each cache's `bus_req` / `bus_req_op` / `bus_req_clc` and grants the bus to one cache at a time with a one-hot `bus_get`. Each grant is held for the requested number of cycles, and the start of every tenure is broadcast so the non-owning caches sample the snoop vector.

## Interface

- `N_MASTER`, default 2: number of L1 controllers sharing the bus.
- `CLC_W`, default 4: width of each cycle-count request field.
- `OWN_W`, default 1: width of `bus_owner`; must equal clog2(`N_MASTER`), minimum 1.

Ports:

- `plusclk`  in  1: the only clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `bus_req`  in  `N_MASTER`: request bit per cache.
- `bus_req_op`  in  `N_MASTER`: 0 = RD (miss address transfer), 1 = WR (write-back / priority write-back).
- `bus_req_clc`  in  `N_MASTER`*`CLC_W`: requested tenure in cycles; master i occupies bits [i*CLC_W +: CLC_W].
- `bus_get`  out  `N_MASTER`: one-hot grant, registered.
- `bus_busy`  out  1: high while any grant is active.
- `bus_owner`  out  `OWN_W`: index of the current or most recent owner.
- `bus_owner_op`  out  1: the op latched at grant.
- `bus_cnt`  out  `CLC_W`: remaining tenure cycles, including the current one.
- `grant_start`  out  1: one-cycle pulse on the first cycle of each tenure (snoop broadcast strobe).

## Operation

- States:
  - IDLE: bus free.
  - BUSY: grant held.
  - TURN: one dead cycle between tenures.
- Arbitration runs in IDLE and TURN on the current-cycle `bus_req`, `bus_req_op` and `bus_req_clc`.
- Winner selection:
  - If any requester has op = WR, pick round-robin among the WR requesters only.
  - Otherwise pick round-robin among all requesters.
  - The round-robin search starts at `ptr`+1 modulo `N_MASTER`.
- On a winner w:
  - Next state is BUSY.
  - `bus_get` becomes one-hot at w.
  - `bus_owner` = w; `bus_owner_op` = op[w].
  - `bus_cnt` = clc[w], or 1 if clc[w] = 0.
  - `ptr` = w.
  - `grant_start` = 1 for that first BUSY cycle.
- No request in IDLE: stay in IDLE.
- No request in TURN: go to IDLE.
- BUSY, each cycle:
  - If `bus_cnt` = 1, go to TURN.
  - Else if `bus_req`[owner] = 0, abort early and go to TURN.
  - Otherwise decrement `bus_cnt`.
- TURN:
  - `bus_get` = 0, `bus_busy` = 0, `bus_cnt` = 0.
  - Arbitration in the same cycle, so back-to-back tenures are separated by exactly one dead cycle.
- Only the owner's `bus_req` is watched during BUSY. Other requests are ignored until TURN.
- `bus_req_op` and `bus_req_clc` are sampled only at the grant edge. Changes during BUSY have no effect.
- `bus_get` is never asserted for more than one master, and never in IDLE or TURN.
- A requester whose `bus_req` rises during BUSY waits for TURN. Under all-requesting, each master is granted at most every `N_MASTER` tenures within its op class.
- WR requesters can starve RD requesters; this is the intended policy (write-backs must drain before snoop data is trusted).

## Timing

- Reset (`rst` = 0, asynchronous):
  - State = IDLE; `ptr` = `N_MASTER`-1, so master 0 wins the first arbitration.
  - `bus_get` = 0, `bus_busy` = 0, `bus_owner` = 0, `bus_owner_op` = 0, `bus_cnt` = 0, `grant_start` = 0.
- Reset asserted mid-tenure drops the grant immediately, without waiting for a clock.
- The first rising edge after `rst` returns to 1 is an IDLE arbitration edge.
- Grant latency: a request high before edge k, with the arbiter in IDLE or TURN, gives `bus_get` high after edge k.
- Tenure: `bus_get` stays high for exactly max(clc,1) cycles unless aborted. An abort drops `bus_get` one cycle after `bus_req`[owner] is seen low.
- `bus_busy` = OR of `bus_get`.
- `grant_start` is high together with the first `bus_get` cycle only.
- `bus_cnt` counts max(clc,1) down to 1 across the tenure.
- `bus_owner` and `bus_owner_op` hold through TURN and IDLE until the next grant.

## Test plan

- Single request: master 0, op=RD, clc=2, request from cycle 1.
  -> `bus_get`=01 for cycles 2–3 with `bus_cnt` 2,1; `grant_start` high in cycle 2; TURN in cycle 4; IDLE after.
- Simultaneous reads: masters 0 and 1, op=RD, clc=2, held high.
  -> Grants alternate 01, 10, 01, each lasting 2 cycles, with 1 dead cycle between; first owner is 0.
- Priority: master 0 RD and master 1 WR, clc=3, requested together.
  -> Master 1 is granted first for 3 cycles with `bus_owner_op`=1; master 0 is granted after one TURN cycle.
- Zero count: master 1 alone, clc=0.
  -> A 1-cycle grant with `bus_cnt`=1, then TURN.
- Early release: master 0 with clc=8 drops `bus_req` on its 3rd grant cycle.
  -> `bus_get` falls on the 4th cycle and the arbiter goes to TURN; pending master 1 is granted on the next cycle.
- Reset mid-tenure: pull `rst` low during BUSY with master 1 as owner.
  -> All outputs go to 0 immediately. After release, with both masters requesting, master 0 is granted first.

Source files
------------

// File: rtl/l1_bus_arbiter.sv
// Shared snoop-bus arbiter: WR-first round-robin, one-hot registered grant held for the requested tenure.
// Grant one edge after request in IDLE/TURN; losers wait (no ack), one dead TURN cycle between tenures.
module l1_bus_arbiter #(
    parameter int N_MASTER = 2,
    parameter int CLC_W    = 4,
    parameter int OWN_W    = 1
) (
    input  logic                      plusclk,
    input  logic                      rst,
    input  logic [N_MASTER-1:0]       bus_req,
    input  logic [N_MASTER-1:0]       bus_req_op,
    input  logic [N_MASTER*CLC_W-1:0] bus_req_clc,
    output logic [N_MASTER-1:0]       bus_get,
    output logic                      bus_busy,
    output logic [OWN_W-1:0]          bus_owner,
    output logic                      bus_owner_op,
    output logic [CLC_W-1:0]          bus_cnt,
    output logic                      grant_start
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_TURN} state_t;

    state_t              state_q, state_d;
    logic [OWN_W-1:0]    ptr_q, ptr_d;
    logic [OWN_W-1:0]    owner_q, owner_d;
    logic                owner_op_q, owner_op_d;
    logic [N_MASTER-1:0] get_q, get_d;
    logic [CLC_W-1:0]    cnt_q, cnt_d;
    logic                start_q, start_d;

    logic [N_MASTER-1:0] wr_req;
    logic [N_MASTER-1:0] cand;
    logic [OWN_W-1:0]    win;
    logic                found;
    logic [CLC_W-1:0]    win_clc;
    int                  idx;

    // Write-backs must drain first, so any WR request masks out all RD requests.
    assign wr_req  = bus_req & bus_req_op;
    assign cand    = (|wr_req) ? wr_req : bus_req;
    assign win_clc = bus_req_clc[int'(win)*CLC_W +: CLC_W];

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 1; i <= N_MASTER; i++) begin
            idx = (int'(ptr_q) + i) % N_MASTER;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = OWN_W'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        owner_op_d = owner_op_q;
        get_d      = get_q;
        cnt_d      = cnt_q;
        start_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_TURN: begin
                state_d = ST_IDLE;
                get_d   = '0;
                cnt_d   = '0;
                if (found) begin
                    state_d    = ST_BUSY;
                    get_d[win] = 1'b1;
                    owner_d    = win;
                    owner_op_d = bus_req_op[win];
                    cnt_d      = (win_clc == '0) ? CLC_W'(1) : win_clc;
                    ptr_d      = win;
                    start_d    = 1'b1;
                end
            end
            ST_BUSY: begin
                // Only the owner's request is watched; others wait for TURN.
                if (cnt_q == CLC_W'(1) || !bus_req[owner_q]) begin
                    state_d = ST_TURN;
                    get_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CLC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                get_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge plusclk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= OWN_W'(N_MASTER - 1);
            owner_q    <= '0;
            owner_op_q <= 1'b0;
            get_q      <= '0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            owner_op_q <= owner_op_d;
            get_q      <= get_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
        end
    end

    assign bus_get      = get_q;
    assign bus_busy     = |get_q;
    assign bus_owner    = owner_q;
    assign bus_owner_op = owner_op_q;
    assign bus_cnt      = cnt_q;
    assign grant_start  = start_q;

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Scoreboard bench for l1_bus_arbiter: directed tenures pushed as expectations, monitor checks each grant.
module tb_l1_bus_arbiter;
    localparam int N  = 2;
    localparam int CW = 4;
    localparam int OW = 1;

    logic            plusclk = 1'b0;
    logic            rst;
    logic [N-1:0]    bus_req;
    logic [N-1:0]    bus_req_op;
    logic [N*CW-1:0] bus_req_clc;
    logic [N-1:0]    bus_get;
    logic            bus_busy;
    logic [OW-1:0]   bus_owner;
    logic            bus_owner_op;
    logic [CW-1:0]   bus_cnt;
    logic            grant_start;

    l1_bus_arbiter #(.N_MASTER(N), .CLC_W(CW), .OWN_W(OW)) dut (
        .plusclk      (plusclk),
        .rst          (rst),
        .bus_req      (bus_req),
        .bus_req_op   (bus_req_op),
        .bus_req_clc  (bus_req_clc),
        .bus_get      (bus_get),
        .bus_busy     (bus_busy),
        .bus_owner    (bus_owner),
        .bus_owner_op (bus_owner_op),
        .bus_cnt      (bus_cnt),
        .grant_start  (grant_start)
    );

    always #5 plusclk = ~plusclk;

    typedef struct {
        int owner;
        int op;
        int cnt;
        int len;
    } ten_t;

    ten_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expected tenure per grant_start and follows it to its end.
    bit   active = 1'b0;
    int   cur_len = 0;
    int   cur_exp_len = 0;
    int   cur_owner = 0;
    int   prev_get = 0;
    int   prev_cnt = 0;
    ten_t e;

    always @(negedge plusclk) begin
        if (!rst) begin
            if (active) check("len_at_reset", cur_len, cur_exp_len);
            active   = 1'b0;
            prev_get = 0;
            prev_cnt = 0;
        end else begin
            check("invariant", int'(bus_busy == (|bus_get) && $onehot0(bus_get) &&
                                    (!grant_start || bus_get != '0)), 1);
            if (grant_start) begin
                if (active) check("len_before_grant", cur_len, cur_exp_len);
                check("gap_before_grant", prev_get, 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_grant: got bus_get=%0d, expected no grant (t=%0t)",
                             bus_get, $time);
                    active = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    check("grant_get", int'(bus_get), 1 << e.owner);
                    check("grant_owner", int'(bus_owner), e.owner);
                    check("grant_op", int'(bus_owner_op), e.op);
                    check("grant_cnt", int'(bus_cnt), e.cnt);
                    cur_len     = 1;
                    cur_exp_len = e.len;
                    cur_owner   = e.owner;
                    active      = 1'b1;
                end
            end else if (active) begin
                if (bus_get != '0) begin
                    cur_len++;
                    check("cnt_dec", int'(bus_cnt), prev_cnt - 1);
                    check("get_hold", int'(bus_get), 1 << cur_owner);
                end else begin
                    check("tenure_len", cur_len, cur_exp_len);
                    check("turn_cnt", int'(bus_cnt), 0);
                    check("owner_hold", int'(bus_owner), cur_owner);
                    active = 1'b0;
                end
            end else begin
                check("no_grant", int'(bus_get), 0);
            end
            prev_get = int'(bus_get);
            prev_cnt = int'(bus_cnt);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge plusclk);
        #1;
    endtask

    task automatic set_m(input int m, input bit r, input bit op, input int clc);
        bus_req[m]               = r;
        bus_req_op[m]            = op;
        bus_req_clc[m*CW +: CW]  = CW'(clc);
    endtask

    task automatic push(input int owner, input int op, input int cnt, input int len);
        ten_t t;
        t.owner = owner;
        t.op    = op;
        t.cnt   = cnt;
        t.len   = len;
        exp_q.push_back(t);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_get"}, int'(bus_get), 0);
        check({tag, "_busy"}, int'(bus_busy), 0);
        check({tag, "_owner"}, int'(bus_owner), 0);
        check({tag, "_op"}, int'(bus_owner_op), 0);
        check({tag, "_cnt"}, int'(bus_cnt), 0);
        check({tag, "_start"}, int'(grant_start), 0);
    endtask

    task automatic do_reset();
        bus_req     = '0;
        bus_req_op  = '0;
        bus_req_clc = '0;
        rst         = 1'b0;
        #1;
        check_zero("rst");
        cycles(2);
        rst = 1'b1;
    endtask

    task automatic end_test(input string name);
        cycles(4);
        check({"queue_empty_", name}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst         = 1'b0;
        bus_req     = '0;
        bus_req_op  = '0;
        bus_req_clc = '0;
        cycles(1);

        // Single request, clc=2.
        do_reset();
        push(0, 0, 2, 2);
        set_m(0, 1'b1, 1'b0, 2);
        cycles(2);
        set_m(0, 1'b0, 1'b0, 2);
        end_test("single");

        // Simultaneous reads alternate 0,1,0.
        do_reset();
        push(0, 0, 2, 2);
        push(1, 0, 2, 2);
        push(0, 0, 2, 2);
        set_m(0, 1'b1, 1'b0, 2);
        set_m(1, 1'b1, 1'b0, 2);
        cycles(8);
        set_m(0, 1'b0, 1'b0, 2);
        set_m(1, 1'b0, 1'b0, 2);
        end_test("rr_reads");

        // WR beats RD regardless of pointer.
        do_reset();
        push(1, 1, 3, 3);
        push(0, 0, 3, 3);
        set_m(0, 1'b1, 1'b0, 3);
        set_m(1, 1'b1, 1'b1, 3);
        cycles(3);
        set_m(1, 1'b0, 1'b1, 3);
        cycles(4);
        set_m(0, 1'b0, 1'b0, 3);
        end_test("priority");

        // Zero count gives a single-cycle tenure.
        do_reset();
        push(1, 0, 1, 1);
        set_m(1, 1'b1, 1'b0, 0);
        cycles(1);
        set_m(1, 1'b0, 1'b0, 0);
        end_test("zero_cnt");

        // Early release after three grant cycles, pending master 1 follows.
        do_reset();
        push(0, 0, 8, 3);
        push(1, 0, 2, 2);
        set_m(0, 1'b1, 1'b0, 8);
        set_m(1, 1'b1, 1'b0, 2);
        cycles(3);
        set_m(0, 1'b0, 1'b0, 8);
        cycles(3);
        set_m(1, 1'b0, 1'b0, 2);
        end_test("early_release");

        // Reset mid-tenure with master 1 owning, then both request.
        do_reset();
        push(1, 1, 5, 1);
        set_m(1, 1'b1, 1'b1, 5);
        cycles(2);
        rst = 1'b0;
        #1;
        check_zero("midrst");
        set_m(0, 1'b1, 1'b0, 2);
        set_m(1, 1'b1, 1'b0, 2);
        push(0, 0, 2, 2);
        push(1, 0, 2, 2);
        cycles(1);
        rst = 1'b1;
        cycles(2);
        set_m(0, 1'b0, 1'b0, 2);
        cycles(3);
        set_m(1, 1'b0, 1'b0, 2);
        end_test("reset_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
